// File: rtl/bcd_display_sched.sv
// Shared double-dabble converter for result/A/B digits, plus a free-running
// eight-digit seven-segment scan multiplexer.
module bcd_display_sched #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A_channel,
    input  logic [7:0]  B_channel,
    input  logic [15:0] input_data,
    input  logic        update,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [19:0] res_bcd,
    output logic [11:0] a_bcd,
    output logic [11:0] b_bcd,
    output logic [7:0]  an,
    output logic [3:0]  scan_digit
);

    localparam int DW = $clog2(REFRESH_DIV);

    typedef enum logic [2:0] {
        IDLE,
        CONV_R,
        CONV_A,
        CONV_B,
        LOAD
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] sh_q;
    logic [19:0] acc_q;
    logic [19:0] rstage_q;
    logic [11:0] astage_q;
    logic        pend_q;
    logic        busy_q;
    logic        done_q;
    logic [19:0] res_q;
    logic [11:0] a_q;
    logic [11:0] b_q;
    logic [19:0] step_d;

    logic [DW-1:0]   div_q;
    logic [2:0]      idx_q;
    logic [7:0]      an_q;
    logic [7:0]      an_d;
    logic [3:0]      dig_q;
    logic [3:0]      dig_d;
    logic [7:0][3:0] dsel;
    logic            on_d;

    function automatic logic [19:0] dd_step(input logic [19:0] v, input logic b);
        logic [19:0] t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        end
        return {t[18:0], b};
    endfunction

    // The snapshot is one 32-bit word {result, A, B} shifted MSB-first
    // through all three conversion phases.
    always_comb step_d = dd_step(acc_q, sh_q[31]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            acc_q    <= '0;
            rstage_q <= '0;
            astage_q <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (update) begin
                        sh_q    <= {input_data, A_channel, B_channel};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV_R;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                CONV_R, CONV_A, CONV_B: begin
                    pend_q <= pend_q | update;
                    sh_q   <= {sh_q[30:0], 1'b0};
                    cnt_q  <= cnt_q + 4'd1;
                    acc_q  <= step_d;
                    if (state_q == CONV_R && cnt_q == 4'd15) begin
                        rstage_q <= step_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= CONV_A;
                    end else if (state_q == CONV_A && cnt_q == 4'd7) begin
                        astage_q <= step_d[11:0];
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= CONV_B;
                    end else if (state_q == CONV_B && cnt_q == 4'd7) begin
                        cnt_q   <= '0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    res_q  <= rstage_q;
                    a_q    <= astage_q;
                    b_q    <= acc_q[11:0];
                    done_q <= 1'b1;
                    if (pend_q || update) begin
                        pend_q  <= 1'b0;
                        sh_q    <= {input_data, A_channel, B_channel};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CONV_R;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        dsel = '0;
        on_d = 1'b0;
        unique case (mode)
            2'd0: begin
                dsel = {12'h000, res_q};
                on_d = (idx_q < 3'd5);
            end
            2'd1: begin
                dsel = {4'h0, b_q, 4'h0, a_q};
                on_d = (idx_q[1:0] != 2'd3);
            end
            default: begin
                dsel = '0;
                on_d = 1'b0;
            end
        endcase
        an_d  = 8'hFF;
        dig_d = 4'h0;
        if (on_d) begin
            an_d[idx_q] = 1'b0;
            dig_d       = dsel[idx_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            dig_q <= '0;
        end else begin
            if (div_q == DW'(REFRESH_DIV - 1)) begin
                div_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            an_q  <= an_d;
            dig_q <= dig_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign res_bcd    = res_q;
    assign a_bcd      = a_q;
    assign b_bcd      = b_q;
    assign an         = an_q;
    assign scan_digit = dig_q;

endmodule

// File: tb/tb_bcd_display_sched.sv
// Bench for bcd_display_sched: arithmetic reference model compared every
// cycle, plus directed literal checks and randomized traffic.
module tb_bcd_display_sched;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  A_channel;
    logic [7:0]  B_channel;
    logic [15:0] input_data;
    logic        update;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [19:0] res_bcd;
    logic [11:0] a_bcd;
    logic [11:0] b_bcd;
    logic [7:0]  an;
    logic [3:0]  scan_digit;

    always #5 clk = ~clk;

    bcd_display_sched #(.REFRESH_DIV(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .A_channel  (A_channel),
        .B_channel  (B_channel),
        .input_data (input_data),
        .update     (update),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .res_bcd    (res_bcd),
        .a_bcd      (a_bcd),
        .b_bcd      (b_bcd),
        .an         (an),
        .scan_digit (scan_digit)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] bcd(input int v, input int nd);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: conversion finishes 33 edges after it starts,
    // scan index is (edges since reset / R) mod 8.
    bit          m_act  = 0;
    int          m_t    = 0;
    bit          m_pend = 0;
    int          m_sr   = 0;
    int          m_sa   = 0;
    int          m_sb   = 0;
    logic        m_busy = 0;
    logic        m_done = 0;
    logic [19:0] m_res  = 0;
    logic [11:0] m_a    = 0;
    logic [11:0] m_b    = 0;
    logic [7:0]  m_an   = 8'hFF;
    logic [3:0]  m_dig  = 0;
    int          m_n    = 0;

    always @(posedge clk or posedge reset) begin : model
        int idx;
        bit on;
        logic [3:0] dg [8];
        if (reset) begin
            m_act = 0; m_t = 0; m_pend = 0;
            m_busy = 0; m_done = 0;
            m_res = 0; m_a = 0; m_b = 0;
            m_an = 8'hFF; m_dig = 0; m_n = 0;
        end else begin
            idx = (m_n / R) % 8;
            m_n++;
            for (int i = 0; i < 8; i++) dg[i] = 4'h0;
            on = 0;
            if (mode == 2'd0) begin
                for (int i = 0; i < 5; i++) dg[i] = m_res[4*i +: 4];
                on = (idx < 5);
            end else if (mode == 2'd1) begin
                for (int i = 0; i < 3; i++) begin
                    dg[i]   = m_a[4*i +: 4];
                    dg[i+4] = m_b[4*i +: 4];
                end
                on = (idx % 4 != 3);
            end
            m_an  = on ? ~(8'd1 << idx) : 8'hFF;
            m_dig = on ? dg[idx] : 4'h0;

            m_done = 0;
            if (m_act) begin
                m_t++;
                if (m_t == 33) begin
                    m_res  = bcd(m_sr, 5);
                    m_a    = 12'(bcd(m_sa, 3));
                    m_b    = 12'(bcd(m_sb, 3));
                    m_done = 1;
                    m_busy = 1;
                    if (m_pend || update) begin
                        m_sr = int'(input_data);
                        m_sa = int'(A_channel);
                        m_sb = int'(B_channel);
                        m_t = 0;
                        m_pend = 0;
                    end else begin
                        m_act = 0;
                    end
                end else if (update) begin
                    m_pend = 1;
                end
            end else if (update) begin
                m_sr = int'(input_data);
                m_sa = int'(A_channel);
                m_sb = int'(B_channel);
                m_act = 1;
                m_t = 0;
                m_busy = 1;
            end else begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("res_bcd", res_bcd, m_res);
        chk("a_bcd", a_bcd, m_a);
        chk("b_bcd", b_bcd, m_b);
        chk("an", an, m_an);
        chk("scan_digit", scan_digit, m_dig);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input logic [15:0] d, input logic [7:0] a, input logic [7:0] b,
                        output int cyc);
        input_data = d;
        A_channel  = a;
        B_channel  = b;
        update     = 1'b1;
        tick();
        update = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic scan_walk(input string nm, input logic [63:0] exp_an,
                             input logic [31:0] exp_dig);
        bit found;
        found = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (an == 8'hFE) begin
                found = 1;
                break;
            end
        end
        chk({nm, "_sync"}, 32'(found), 32'd1);
        for (int s = 0; s < 8; s++) begin
            chk({nm, "_an"}, an, exp_an[8*s +: 8]);
            chk({nm, "_dig"}, scan_digit, exp_dig[4*s +: 4]);
            repeat (R) tick();
        end
    endtask

    int          cyc;
    int          first;
    int          second;
    bit          dropped;
    bit          flag;
    logic [15:0] bv_r [7];
    logic [19:0] bv_re [7];
    logic [7:0]  bv_ab [4];
    logic [11:0] bv_abe [4];

    initial begin
        reset = 1'b1;
        update = 1'b0;
        input_data = '0;
        A_channel = '0;
        B_channel = '0;
        mode = 2'd0;
        tick();
        chk("rst_res", res_bcd, 20'h0);
        chk("rst_an", an, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        conv(16'd65535, 8'd255, 8'd0, cyc);
        chk("lat_65535", cyc, 33);
        chk("res_65535", res_bcd, 20'h65535);
        chk("a_255", a_bcd, 12'h255);
        chk("b_0", b_bcd, 12'h000);
        tick();
        chk("busy_fall", busy, 1'b0);

        bv_r  = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd9999, 16'd10000};
        bv_re = '{20'h0, 20'h9, 20'h10, 20'h99, 20'h100, 20'h9999, 20'h10000};
        bv_ab  = '{8'd9, 8'd10, 8'd99, 8'd100};
        bv_abe = '{12'h009, 12'h010, 12'h099, 12'h100};
        for (int i = 0; i < 7; i++) begin
            conv(bv_r[i], bv_ab[i % 4], bv_ab[(i + 1) % 4], cyc);
            chk("bnd_lat", cyc, 33);
            chk("bnd_res", res_bcd, bv_re[i]);
            chk("bnd_a", a_bcd, bv_abe[i % 4]);
            chk("bnd_b", b_bcd, bv_abe[(i + 1) % 4]);
            repeat (2) tick();
        end

        input_data = 16'd1234;
        A_channel = 8'd1;
        B_channel = 8'd2;
        update = 1'b1;
        tick();
        update = 1'b0;
        first = -1;
        second = -1;
        dropped = 0;
        for (int i = 1; i <= 80; i++) begin
            if (i == 10) update = 1'b1;
            if (i == 20) begin
                input_data = 16'd4321;
                A_channel = 8'd7;
                B_channel = 8'd8;
            end
            tick();
            update = 1'b0;
            if (!busy) dropped = 1;
            if (done) begin
                if (first < 0) begin
                    first = i;
                    chk("pend_res1", res_bcd, 20'h01234);
                end else begin
                    second = i;
                    chk("pend_res2", res_bcd, 20'h04321);
                    chk("pend_a2", a_bcd, 12'h007);
                    chk("pend_b2", b_bcd, 12'h008);
                    break;
                end
            end
        end
        chk("pend_first", first, 33);
        chk("pend_second", second, 66);
        chk("pend_busy", 32'(dropped), 32'd0);
        repeat (2) tick();

        conv(16'd12345, 8'd123, 8'd45, cyc);
        chk("scan_lat", cyc, 33);
        mode = 2'd0;
        scan_walk("scan0", 64'hFF_FF_FF_EF_F7_FB_FD_FE, 32'h0001_2345);
        mode = 2'd1;
        repeat (2) tick();
        scan_walk("scan1", 64'hFF_BF_DF_EF_FF_FB_FD_FE, 32'h0045_0123);
        mode = 2'd0;

        input_data = 16'd777;
        A_channel = 8'd33;
        B_channel = 8'd44;
        update = 1'b1;
        tick();
        update = 1'b0;
        repeat (11) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_res", res_bcd, 20'h0);
        chk("mid_rst_a", a_bcd, 12'h0);
        chk("mid_rst_b", b_bcd, 12'h0);
        chk("mid_rst_an", an, 8'hFF);
        chk("mid_rst_dig", scan_digit, 4'h0);
        chk("mid_rst_busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        flag = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) flag = 1;
        end
        chk("mid_rst_nodone", 32'(flag), 32'd0);
        conv(16'd4321, 8'd56, 8'd78, cyc);
        chk("post_rst_lat", cyc, 33);
        chk("post_rst_res", res_bcd, 20'h04321);
        chk("post_rst_a", a_bcd, 12'h056);
        chk("post_rst_b", b_bcd, 12'h078);
        repeat (2) tick();

        mode = 2'd3;
        tick();
        input_data = 16'd321;
        A_channel = 8'd4;
        B_channel = 8'd5;
        update = 1'b1;
        tick();
        update = 1'b0;
        flag = 0;
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (an !== 8'hFF) flag = 1;
            if (done) begin
                cyc = i;
                break;
            end
        end
        chk("m3_an", 32'(flag), 32'd0);
        chk("m3_lat", cyc, 33);
        chk("m3_res", res_bcd, 20'h00321);
        chk("m3_a", a_bcd, 12'h004);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            update = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) input_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) A_channel = 8'($urandom);
            if ($urandom_range(0, 3) == 0) B_channel = 8'($urandom);
            tick();
        end
        update = 1'b0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
